// File: rtl/systolic_pkg.sv
// Shared constants, mode encoding and lane-packing helper for the
// systolic array datapath (operand feeders, skew/deskew stages).
package systolic_pkg;

    localparam int OPND_BWIDTH            = 8;
    localparam int ACC_BWIDTH             = 32;
    localparam int PE_ARRAY_NUM_ROWS      = 32;
    localparam int PE_ARRAY_NUM_ROWS_LOG2 = 5;
    localparam int PE_ARRAY_NUM_COLS      = 32;
    localparam int PE_ARRAY_NUM_COLS_LOG2 = 5;

    typedef enum logic {
        MODE_SKEW   = 1'b0,
        MODE_DESKEW = 1'b1
    } mode_e;

    // Lane i of a packed row occupies bits [lane_lsb(i)+bwidth-1 : lane_lsb(i)].
    function automatic int lane_lsb(input int lane, input int bwidth);
        return lane * bwidth;
    endfunction

endpackage

// File: rtl/operand_skew_buffer_skew_lane.sv
// One lane of the skew buffer: a {valid, data} delay line whose effective
// length is picked at run time by a tap index, followed by an output register.
module skew_lane #(
    parameter int DEPTH       = 31,
    parameter int TAP_BWIDTH  = 5,
    parameter int LANE_BWIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [TAP_BWIDTH-1:0]  tap,
    input  logic                   in_valid,
    input  logic [LANE_BWIDTH-1:0] in_data,
    output logic                   out_valid,
    output logic [LANE_BWIDTH-1:0] out_data,
    output logic                   any_valid
);

    logic [DEPTH-1:0]       stage_v;
    logic [LANE_BWIDTH-1:0] stage_d [DEPTH];

    // chain[0] is the lane input, chain[k] is the output of stage k-1.
    logic [DEPTH:0]         chain_v;
    logic [LANE_BWIDTH-1:0] chain_d [DEPTH+1];
    logic                   tap_v;
    logic [LANE_BWIDTH-1:0] tap_d;

    always_comb begin
        chain_v    = {stage_v, in_valid};
        chain_d[0] = in_data;
        for (int k = 0; k < DEPTH; k++) begin
            chain_d[k+1] = stage_d[k];
        end
        tap_v = chain_v[0];
        tap_d = chain_d[0];
        for (int k = 1; k <= DEPTH; k++) begin
            if (int'(tap) == k) begin
                tap_v = chain_v[k];
                tap_d = chain_d[k];
            end
        end
    end

    // Stages at or beyond the tap are held empty so they never count as busy.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            stage_v   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                stage_d[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (k < int'(tap)) begin
                    stage_v[k] <= chain_v[k];
                    stage_d[k] <= chain_d[k];
                end else begin
                    stage_v[k] <= 1'b0;
                    stage_d[k] <= '0;
                end
            end
            out_valid <= tap_v;
            out_data  <= tap_d;
        end
    end

    assign any_valid = (|stage_v) | out_valid;

endmodule

// File: rtl/operand_skew_buffer.sv
// Lane-skew stage between an operand SRAM row and the PE-array edge:
// skew mode delays lane i by i cycles, deskew mode by NUM_LANES-1-i cycles.
module operand_skew_buffer
    import systolic_pkg::*;
#(
    parameter int NUM_LANES      = PE_ARRAY_NUM_ROWS,
    parameter int NUM_LANES_LOG2 = PE_ARRAY_NUM_ROWS_LOG2,
    parameter int LANE_BWIDTH    = OPND_BWIDTH
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             STALL,
    input  logic                             FLUSH_in,
    input  logic                             DESKEW_in,
    input  logic [NUM_LANES-1:0]             LANE_MASK_in,
    input  logic                             D_VALID_in,
    input  logic [NUM_LANES*LANE_BWIDTH-1:0] D_in,
    output logic [NUM_LANES*LANE_BWIDTH-1:0] D_out,
    output logic [NUM_LANES-1:0]             VALID_out,
    output logic                             BUSY_out,
    output logic                             DRAIN_out
);

    // Handshake: valid-only, there is no ready. A row is taken on every edge
    // where D_VALID_in=1 and STALL=0; a row offered during STALL is dropped.
    mode_e                mode_q;
    logic                 busy;
    logic                 busy_prev_q;
    logic                 kill_prev_q;
    logic [NUM_LANES-1:0] lane_busy;

    assign busy = |lane_busy;

    // The tap only moves while the pipe is empty, so in-flight rows keep their latency.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q      <= MODE_SKEW;
            busy_prev_q <= 1'b0;
            kill_prev_q <= 1'b1;
        end else begin
            busy_prev_q <= busy;
            kill_prev_q <= FLUSH_in;
            if (!FLUSH_in && !STALL && !D_VALID_in && !busy) begin
                mode_q <= mode_e'(DESKEW_in);
            end
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam int SKEW_TAP   = i;
        localparam int DESKEW_TAP = NUM_LANES - 1 - i;

        logic [NUM_LANES_LOG2-1:0] tap;
        logic                      in_valid;
        logic [LANE_BWIDTH-1:0]    in_data;

        assign tap      = (mode_q == MODE_DESKEW) ? NUM_LANES_LOG2'(DESKEW_TAP)
                                                  : NUM_LANES_LOG2'(SKEW_TAP);
        assign in_valid = D_VALID_in & LANE_MASK_in[i];
        assign in_data  = in_valid ? D_in[lane_lsb(i, LANE_BWIDTH) +: LANE_BWIDTH] : '0;

        skew_lane #(
            .DEPTH       (NUM_LANES - 1),
            .TAP_BWIDTH  (NUM_LANES_LOG2),
            .LANE_BWIDTH (LANE_BWIDTH)
        ) u_lane (
            .clk       (CLK),
            .rst       (RST),
            .stall     (STALL),
            .flush     (FLUSH_in),
            .tap       (tap),
            .in_valid  (in_valid),
            .in_data   (in_data),
            .out_valid (VALID_out[i]),
            .out_data  (D_out[lane_lsb(i, LANE_BWIDTH) +: LANE_BWIDTH]),
            .any_valid (lane_busy[i])
        );
    end

    assign BUSY_out  = busy;
    assign DRAIN_out = busy_prev_q & ~busy & ~kill_prev_q;

endmodule
